// File: rtl/mcd_snd_out.sv
// rtl/mcd_snd_out.sv - MCD sound output stage: Fs strobes, mute gain, 16-bit I2S serializer (option: MCD_SND_MUTE_RAMP_EN)
module mcd_snd_out #(
    parameter int unsigned PHASE_INC = 7576322,
    parameter int unsigned GAIN_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mute,
    input  logic [15:0] snd_l,
    input  logic [15:0] snd_r,
    output logic        snd_clk,
    output logic        snd_next_sample,
    output logic        dac_mclk,
    output logic        dac_bclk,
    output logic        dac_lrck,
    output logic        dac_sdat,
    output logic        muted
);

    localparam logic [23:0] INC      = PHASE_INC[23:0];
    localparam logic [8:0]  STEP     = GAIN_STEP[8:0];
    localparam logic [8:0]  GAIN_MAX = 9'd256;

    logic [23:0] acc;
    logic [24:0] acc_sum;
    logic [8:0]  p;
    logic [8:0]  p_nxt;
    logic [8:0]  gain;
    logic [15:0] out_l;
    logic [15:0] out_r;

    assign acc_sum = {1'b0, acc} + {1'b0, INC};
    assign p_nxt   = p + 9'd1;

    // Phase accumulator; its carry, registered, is the 512xFs strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= 24'd0;
            snd_clk <= 1'b0;
        end else begin
            acc     <= acc_sum[23:0];
            snd_clk <= acc_sum[24];
        end
    end

    // Position within the stereo frame; every DAC clock is a bit of it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p <= 9'd0;
        end else if (snd_clk) begin
            p <= p_nxt;
        end
    end

    assign snd_next_sample = snd_clk & (p == 9'd511);
    assign dac_mclk        = p[0];
    assign dac_bclk        = p[2];
    assign dac_lrck        = p[8];

    // Signed sample times unsigned gain; bits 23:8 are the floor of >>>8 truncated to 16 bits
    logic signed [25:0] prod_l;
    logic signed [25:0] prod_r;
    logic               unused_prod;

    assign prod_l      = $signed(snd_l) * $signed({1'b0, gain});
    assign prod_r      = $signed(snd_r) * $signed({1'b0, gain});
    assign unused_prod = ^{prod_l[25:24], prod_l[7:0], prod_r[25:24], prod_r[7:0]};

    // Capture both channels once per sample, using the gain before this sample's update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_l <= 16'd0;
            out_r <= 16'd0;
        end else if (snd_next_sample) begin
            out_l <= prod_l[23:8];
            out_r <= prod_r[23:8];
        end
    end

    // Slot 1 carries the MSB one BCLK after LRCK changes; slots 0 and 17..31 are zero padding
    logic [4:0]  slot_nxt;
    logic [15:0] word_nxt;
    logic [3:0]  bit_idx;
    logic        slot_live;

    assign slot_nxt  = p_nxt[7:3];
    assign word_nxt  = p_nxt[8] ? out_r : out_l;
    assign bit_idx   = 4'd0 - slot_nxt[3:0];
    assign slot_live = (slot_nxt != 5'd0) && (slot_nxt <= 5'd16);

    // Serial data changes only as BCLK falls, so the DAC samples it mid-bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dac_sdat <= 1'b0;
        end else if (snd_clk && (p_nxt[2:0] == 3'd0)) begin
            dac_sdat <= slot_live & word_nxt[bit_idx];
        end
    end

`ifdef MCD_SND_MUTE_RAMP_EN
    typedef enum logic [1:0] {MUTED, RAMP_UP, PLAY, RAMP_DN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  gain_nxt;
    logic [9:0]  up_sum;

    assign up_sum = {1'b0, gain} + {1'b0, STEP};

    // Ramp gain toward the requested level; a reversal holds the gain for one sample
    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        case (state)
            MUTED: begin
                if (!mute) state_nxt = RAMP_UP;
            end
            RAMP_UP: begin
                if (mute) begin
                    state_nxt = RAMP_DN;
                end else if (up_sum >= {1'b0, GAIN_MAX}) begin
                    gain_nxt  = GAIN_MAX;
                    state_nxt = PLAY;
                end else begin
                    gain_nxt = up_sum[8:0];
                end
            end
            PLAY: begin
                if (mute) state_nxt = RAMP_DN;
            end
            RAMP_DN: begin
                if (!mute) begin
                    state_nxt = RAMP_UP;
                end else if (gain <= STEP) begin
                    gain_nxt  = 9'd0;
                    state_nxt = MUTED;
                end else begin
                    gain_nxt = gain - STEP;
                end
            end
            default: state_nxt = MUTED;
        endcase
    end

    // Gain state advances only at sample boundaries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MUTED;
            gain  <= 9'd0;
        end else if (snd_next_sample) begin
            state <= state_nxt;
            gain  <= gain_nxt;
        end
    end

    assign muted = (state == MUTED) && (gain == 9'd0);
`else
    // Hard mute: gain snaps to silence or pass-through at each sample boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gain  <= 9'd0;
            muted <= 1'b1;
        end else if (snd_next_sample) begin
            gain  <= mute ? 9'd0 : GAIN_MAX;
            muted <= mute;
        end
    end
`endif

endmodule

// File: tb/tb_mcd_snd_out.sv
// tb/tb_mcd_snd_out.sv - self-checking bench for mcd_snd_out with an I2S frame scoreboard
module tb_mcd_snd_out;

    localparam int PINC = 8388608;
    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mute = 1'b1;
    logic [15:0] snd_l = 16'd0;
    logic [15:0] snd_r = 16'd0;
    logic        snd_clk;
    logic        snd_next_sample;
    logic        dac_mclk;
    logic        dac_bclk;
    logic        dac_lrck;
    logic        dac_sdat;
    logic        muted;

    mcd_snd_out #(.PHASE_INC(PINC), .GAIN_STEP(STEP)) dut (
        .clk(clk), .rst(rst), .mute(mute), .snd_l(snd_l), .snd_r(snd_r),
        .snd_clk(snd_clk), .snd_next_sample(snd_next_sample),
        .dac_mclk(dac_mclk), .dac_bclk(dac_bclk), .dac_lrck(dac_lrck),
        .dac_sdat(dac_sdat), .muted(muted)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] exp_q[$];
    logic        mon_en  = 1'b0;

    int          m_gain  = 0;
    int          m_state = 0;
    logic        m_muted = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] scale(input logic [15:0] x, input int g);
        int          prod;
        logic [31:0] sh;
        prod = int'($signed(x)) * g;
        sh   = prod >>> 8;
        return sh[15:0];
    endfunction

    task automatic model_step(input logic m);
`ifdef MCD_SND_MUTE_RAMP_EN
        case (m_state)
            0: if (!m) m_state = 1;
            1: if (m) m_state = 3;
               else begin
                   m_gain = (m_gain + STEP > 256) ? 256 : m_gain + STEP;
                   if (m_gain == 256) m_state = 2;
               end
            2: if (m) m_state = 3;
            default: if (!m) m_state = 1;
               else begin
                   m_gain = (m_gain - STEP < 0) ? 0 : m_gain - STEP;
                   if (m_gain == 0) m_state = 0;
               end
        endcase
        m_muted = (m_state == 0) && (m_gain == 0);
`else
        m_gain  = m ? 0 : 256;
        m_muted = m;
`endif
    endtask

    task automatic do_sample(input logic [15:0] l, input logic [15:0] r, input logic m);
        int n;
        snd_l = l;
        snd_r = r;
        mute  = m;
        n = 0;
        @(negedge clk);
        while (snd_next_sample !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("sample_wait", 32'(n < 1100), 32'd1);
        exp_q.push_back({scale(l, m_gain), scale(r, m_gain)});
        model_step(m);
        @(posedge clk);
        #1;
        chk("muted", 32'(muted), 32'(m_muted));
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return snd_clk;
            1:       return dac_mclk;
            default: return dac_bclk;
        endcase
    endfunction

    task automatic measure(input int w, input string tag, input int expv);
        int   n;
        logic prev;
        n = 0;
        do begin prev = sig(w); @(negedge clk); n++; end while (!(sig(w) && !prev) && n < 200);
        n = 0;
        do begin prev = sig(w); @(negedge clk); n++; end while (!(sig(w) && !prev) && n < 200);
        chk(tag, n, expv);
    endtask

    // I2S receiver: sample data on BCLK rise, score a frame after its last right slot
    int          slot = 0;
    logic [15:0] word = 16'd0;
    logic [15:0] got_l = 16'd0;
    logic        pad_err = 1'b0;
    logic        prev_bclk = 1'b0;
    logic        prev_lrck = 1'b0;
    logic [31:0] expw;

    always @(negedge clk) begin
        if (mon_en) begin
            if (dac_lrck !== prev_lrck) slot = 0;
            if (dac_bclk && !prev_bclk) begin
                if (slot >= 1 && slot <= 16) word[16 - slot] = dac_sdat;
                else if (dac_sdat !== 1'b0) pad_err = 1'b1;
                if (slot == 31) begin
                    if (!dac_lrck) begin
                        got_l = word;
                    end else begin
                        chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                        expw = (exp_q.size() != 0) ? exp_q.pop_front() : 32'd0;
                        chk("left_word", 32'(got_l), 32'(expw[31:16]));
                        chk("right_word", 32'(word), 32'(expw[15:0]));
                        chk("pad_slots_zero", 32'(pad_err), 32'd0);
                        pad_err = 1'b0;
                    end
                end
                slot++;
            end
        end
        prev_bclk = dac_bclk;
        prev_lrck = dac_lrck;
    end

    // Sample strobe must ride a snd_clk strobe; sample and LRCK periods are 1024 clk
    int   cyc = 0;
    int   last_ns = -1;
    int   last_lr = -1;
    logic prev_lr_p = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (snd_next_sample) begin
                chk("nsamp_on_snd_clk", 32'(snd_clk), 32'd1);
                if (last_ns >= 0) chk("nsamp_period", cyc - last_ns, 1024);
                last_ns = cyc;
            end
            if (dac_lrck && !prev_lr_p) begin
                if (last_lr >= 0) chk("lrck_period", cyc - last_lr, 1024);
                last_lr = cyc;
            end
        end
        prev_lr_p = dac_lrck;
    end

    initial begin
        int n;
        int first_sc;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_snd_clk", 32'(snd_clk), 32'd0);
        chk("rst_next_sample", 32'(snd_next_sample), 32'd0);
        chk("rst_mclk", 32'(dac_mclk), 32'd0);
        chk("rst_bclk", 32'(dac_bclk), 32'd0);
        chk("rst_lrck", 32'(dac_lrck), 32'd0);
        chk("rst_sdat", 32'(dac_sdat), 32'd0);
        chk("rst_muted", 32'(muted), 32'd1);

        rst    = 1'b1;
        mon_en = 1'b1;
        exp_q.push_back(32'd0);

        measure(0, "snd_clk_period", 2);
        measure(1, "mclk_period", 4);
        measure(2, "bclk_period", 16);

        do_sample(16'h8001, 16'h7FFE, 1'b0);
        do_sample(16'h8001, 16'h7FFE, 1'b0);
        do_sample(16'hFFFF, 16'h8000, 1'b0);
        do_sample(16'h1234, 16'hEDCB, 1'b1);
        do_sample(16'h7FFF, 16'h8000, 1'b1);
        do_sample(16'($urandom), 16'($urandom), 1'b0);
        do_sample(16'($urandom), 16'($urandom), 1'b0);
        do_sample(16'h0100, 16'hFF00, 1'b0);

`ifdef MCD_SND_MUTE_RAMP_EN
        for (int i = 0; i < 70 && !(m_state == 1 && m_gain == 100); i++)
            do_sample(16'($urandom), 16'($urandom), 1'b0);
        for (int i = 0; i < 30 && m_gain != 40; i++)
            do_sample(16'($urandom), 16'($urandom), 1'b1);
        do_sample(16'hFFFF, 16'h7FFF, 1'b0);
        do_sample(16'h8000, 16'h0100, 1'b0);
        do_sample(16'($urandom), 16'($urandom), 1'b0);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", exp_q.size(), 0);

        mon_en = 1'b0;
        n = 0;
        while (snd_next_sample !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_sync", 32'(n < 1100), 32'd1);
        repeat (601) @(negedge clk);
        chk("pre_rst_lrck", 32'(dac_lrck), 32'd1);
        chk("pre_rst_muted", 32'(muted), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("async_snd_clk", 32'(snd_clk), 32'd0);
        chk("async_next_sample", 32'(snd_next_sample), 32'd0);
        chk("async_mclk", 32'(dac_mclk), 32'd0);
        chk("async_bclk", 32'(dac_bclk), 32'd0);
        chk("async_lrck", 32'(dac_lrck), 32'd0);
        chk("async_sdat", 32'(dac_sdat), 32'd0);
        chk("async_muted", 32'(muted), 32'd1);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        n = 0;
        first_sc = 0;
        do begin
            @(negedge clk);
            n++;
            if (first_sc == 0 && snd_clk) first_sc = n;
        end while (!dac_lrck && n < 2000);
        chk("first_snd_clk_after_rst", first_sc, 2);
        chk("lrck_rise_after_rst", n, 513);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
